// File: rtl/packet_tx_scheduler.sv
// Packet transmit scheduler: serialises preamble, sync byte and payload MSB-first over a valid/ready bit link.
// Build option: define PKT_TX_CRC8_EN to append a CRC-8 (poly 0x07) byte computed over the payload.
module packet_tx_scheduler #(
  parameter int         PACKET_WIDTH     = 8,
  parameter int         PREAMBLE_BYTES   = 2,
  parameter logic [7:0] PREAMBLE_PATTERN = 8'h55,
  parameter logic [7:0] SYNC_WORD        = 8'hD3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PACKET_WIDTH-1:0][7:0] sys_packet,
  input  logic                         send,
  input  logic                         bit_ready,
  output logic                         bit_out,
  output logic                         bit_valid,
  output logic                         busy,
  output logic                         tx_done,
  output logic                         overrun
);

  localparam int MAX_BYTES = (PACKET_WIDTH > PREAMBLE_BYTES) ? PACKET_WIDTH : PREAMBLE_BYTES;
  localparam int BYTE_W    = $clog2(MAX_BYTES + 1);
  localparam int IDX_W     = (PACKET_WIDTH > 1) ? $clog2(PACKET_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD,
`ifdef PKT_TX_CRC8_EN
    CRC,
`endif
    DONE
  } state_t;

  state_t                         state;
  state_t                         adv_state;
  logic [PACKET_WIDTH-1:0][7:0]   shadow;
  logic [PACKET_WIDTH-1:0][7:0]   pending;
  logic [PACKET_WIDTH-1:0][7:0]   load_src;
  logic                           pending_full;
  logic [2:0]                     bit_cnt;
  logic [BYTE_W-1:0]              byte_cnt;
  logic [IDX_W-1:0]               idx;
  logic [IDX_W-1:0]               idx_next;
  logic [7:0]                     cur_byte;
  logic [7:0]                     next_byte;
  logic                           last_byte;
  logic                           xfer;
  logic                           start;

`ifdef PKT_TX_CRC8_EN
  logic [7:0] crc_reg;
  logic [7:0] crc_next;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // Folding in the bit currently on the wire gives the final CRC on the last payload transfer.
  assign crc_next = crc_step(crc_reg, bit_out);
`endif

  assign xfer     = bit_valid && bit_ready;
  assign idx      = byte_cnt[IDX_W-1:0];
  assign idx_next = idx + IDX_W'(1);
  // A DONE cycle restarts immediately from the pending slot, or from a packet arriving that cycle.
  assign start    = (state == IDLE && send) || (state == DONE && (pending_full || send));
  assign load_src = (state == DONE && pending_full) ? pending : sys_packet;

  always_comb begin
    cur_byte  = 8'h00;
    next_byte = 8'h00;
    last_byte = 1'b1;
    adv_state = state;
    case (state)
      PREAMBLE: begin
        cur_byte  = PREAMBLE_PATTERN;
        last_byte = (byte_cnt == BYTE_W'(PREAMBLE_BYTES - 1));
        next_byte = last_byte ? SYNC_WORD : PREAMBLE_PATTERN;
        adv_state = SYNC;
      end
      SYNC: begin
        cur_byte  = SYNC_WORD;
        next_byte = shadow[0];
        adv_state = PAYLOAD;
      end
      PAYLOAD: begin
        cur_byte  = shadow[idx];
        last_byte = (byte_cnt == BYTE_W'(PACKET_WIDTH - 1));
`ifdef PKT_TX_CRC8_EN
        next_byte = last_byte ? crc_next : shadow[idx_next];
        adv_state = CRC;
`else
        next_byte = shadow[idx_next];
        adv_state = DONE;
`endif
      end
`ifdef PKT_TX_CRC8_EN
      CRC: begin
        cur_byte  = crc_reg;
        adv_state = DONE;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shadow       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      bit_cnt      <= 3'd0;
      byte_cnt     <= '0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      overrun      <= 1'b0;
`ifdef PKT_TX_CRC8_EN
      crc_reg      <= 8'h00;
`endif
    end else begin
      tx_done <= 1'b0;
      if (start) begin
        state     <= PREAMBLE;
        shadow    <= load_src;
        bit_valid <= 1'b1;
        busy      <= 1'b1;
        bit_out   <= PREAMBLE_PATTERN[7];
        bit_cnt   <= 3'd0;
        byte_cnt  <= '0;
`ifdef PKT_TX_CRC8_EN
        crc_reg   <= 8'h00;
`endif
        if (state == DONE && pending_full) begin
          if (send) pending <= sys_packet;
          else      pending_full <= 1'b0;
        end
      end else if (state == DONE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state != IDLE) begin
        if (send) begin
          if (!pending_full) begin
            pending      <= sys_packet;
            pending_full <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
        if (xfer) begin
`ifdef PKT_TX_CRC8_EN
          if (state == PAYLOAD) crc_reg <= crc_next;
`endif
          if (bit_cnt != 3'd7) begin
            bit_cnt <= bit_cnt + 3'd1;
            bit_out <= cur_byte[3'd6 - bit_cnt];
          end else begin
            bit_cnt <= 3'd0;
            if (!last_byte) begin
              byte_cnt <= byte_cnt + BYTE_W'(1);
              bit_out  <= next_byte[7];
            end else begin
              byte_cnt <= '0;
              state    <= adv_state;
              if (adv_state == DONE) begin
                bit_valid <= 1'b0;
                bit_out   <= 1'b0;
                tx_done   <= 1'b1;
              end else begin
                bit_out <= next_byte[7];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_tx_scheduler.sv
// Self-checking bench for packet_tx_scheduler: table of packets plus hand-written multi-cycle sequences,
// compared against a byte-level stream model (preamble, sync, payload, optional CRC).
module tb_packet_tx_scheduler;

`ifdef PKT_TX_CRC8_EN
  localparam int PW        = 9;
  localparam int CRC_BYTES = 1;
`else
  localparam int PW        = 8;
  localparam int CRC_BYTES = 0;
`endif
  localparam int PB    = 2;
  localparam int NBITS = (PB + 1 + PW + CRC_BYTES) * 8;

  typedef logic [PW-1:0][7:0] pkt_t;
  typedef struct {
    pkt_t pkt;
    int   ready_pct;
    int   exp_bits;
  } vec_t;

  logic clk, reset, send, bit_ready;
  logic bit_out, bit_valid, busy, tx_done, overrun;
  pkt_t sys_packet;

  int checks = 0;
  int errors = 0;
  int ready_pct = 100;
  bit got[$];
  bit exp_q[$];

  packet_tx_scheduler #(
    .PACKET_WIDTH(PW), .PREAMBLE_BYTES(PB),
    .PREAMBLE_PATTERN(8'h55), .SYNC_WORD(8'hD3)
  ) dut (
    .clk(clk), .reset(reset), .sys_packet(sys_packet), .send(send),
    .bit_ready(bit_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .busy(busy), .tx_done(tx_done), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bit_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2 bit_ready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic checkn(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Collector: records each accepted bit and checks that a stalled bit is held.
  initial begin
    bit   stall = 1'b0;
    logic held  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check1("stall_hold_valid", bit_valid, 1'b1);
          check1("stall_hold_bit", bit_out, held);
        end
        if (bit_valid === 1'b1 && bit_ready === 1'b1) got.push_back(bit_out);
        stall = (bit_valid === 1'b1 && bit_ready === 1'b0);
        held  = bit_out;
      end
    end
  end

  function automatic logic [7:0] crc8(input pkt_t p);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < PW; i++) begin
      c = c ^ p[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic void add_expected(input pkt_t p);
    logic [7:0] bytes[$];
    for (int i = 0; i < PB; i++) bytes.push_back(8'h55);
    bytes.push_back(8'hD3);
    for (int i = 0; i < PW; i++) bytes.push_back(p[i]);
    if (CRC_BYTES != 0) bytes.push_back(crc8(p));
    foreach (bytes[j]) for (int b = 7; b >= 0; b--) exp_q.push_back(bytes[j][b]);
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    for (int i = 0; i < PW; i++) p[i] = 8'($urandom);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input pkt_t p);
    sys_packet = p;
    send = 1'b1;
    step();
    send = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    do begin
      step();
      n++;
    end while (tx_done !== 1'b1 && n < limit);
    check1({name, "_tx_done"}, tx_done, 1'b1);
  endtask

  task automatic wait_bits(input string name, input int k, input int limit);
    int n = 0;
    while (got.size() < k && n < limit) begin
      step();
      n++;
    end
    check1({name, "_bits_reached"}, got.size() >= k, 1'b1);
  endtask

  task automatic compare_stream(input string name);
    int nbad = 0;
    checkn({name, "_stream_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] != exp_q[i]) nbad++;
    checkn({name, "_stream_bit_errors"}, nbad, 0);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t vt[4];
    pkt_t p, a, b, c;
    int   vcnt, idle_valid;
    logic [7:0] crc_seen;

    reset = 1'b0;
    send = 1'b0;
    sys_packet = '0;
    repeat (3) step();
    check1("reset_bit_valid", bit_valid, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_tx_done", tx_done, 1'b0);
    check1("reset_overrun", overrun, 1'b0);
    check1("reset_bit_out", bit_out, 1'b0);
    #3 reset = 1'b1;
    repeat (2) step();

    // Basic: exact cycle timing with bit_ready held high
    for (int i = 0; i < PW; i++) p[i] = 8'(i);
    add_expected(p);
    send_pkt(p);
    vcnt = 0;
    for (int k = 1; k <= NBITS + 2; k++) begin
      if (k <= NBITS && bit_valid === 1'b1) vcnt++;
      if (k == 1) check1("basic_first_valid", bit_valid, 1'b1);
      if (k == NBITS) check1("basic_no_early_done", tx_done, 1'b0);
      if (k == NBITS + 1) begin
        check1("basic_tx_done", tx_done, 1'b1);
        check1("basic_done_valid_low", bit_valid, 1'b0);
      end
      if (k == NBITS + 2) check1("basic_idle_busy", busy, 1'b0);
      if (k < NBITS + 2) step();
    end
    checkn("basic_valid_cycles", vcnt, NBITS);
    compare_stream("basic");

    // Table of packets under varying backpressure
    for (int i = 0; i < PW; i++) vt[0].pkt[i] = 8'(i);
    vt[0].ready_pct = 50;  vt[0].exp_bits = NBITS;
    vt[1].pkt = rand_pkt(); vt[1].ready_pct = 30;  vt[1].exp_bits = NBITS;
    vt[2].pkt = rand_pkt(); vt[2].ready_pct = 70;  vt[2].exp_bits = NBITS;
    vt[3].pkt = rand_pkt(); vt[3].ready_pct = 100; vt[3].exp_bits = NBITS;
    for (int v = 0; v < 4; v++) begin
      ready_pct = vt[v].ready_pct;
      repeat (2) step();
      add_expected(vt[v].pkt);
      send_pkt(vt[v].pkt);
      wait_done($sformatf("vec%0d", v), 4000);
      checkn($sformatf("vec%0d_bit_count", v), got.size(), vt[v].exp_bits);
      compare_stream($sformatf("vec%0d", v));
      step();
      check1($sformatf("vec%0d_idle_busy", v), busy, 1'b0);
    end

    // Back-to-back: B queued during A's payload starts right after A's DONE
    ready_pct = 100;
    repeat (2) step();
    for (int i = 0; i < PW; i++) begin
      a[i] = 8'hAA;
      b[i] = 8'h0F;
    end
    add_expected(a);
    add_expected(b);
    send_pkt(a);
    wait_bits("b2b_payload", (PB + 1) * 8 + 8, 500);
    send_pkt(b);
    wait_done("b2b_a", 500);
    step();
    check1("b2b_b_first_valid", bit_valid, 1'b1);
    check1("b2b_b_busy", busy, 1'b1);
    wait_done("b2b_b", 500);
    compare_stream("b2b");
    check1("b2b_no_overrun", overrun, 1'b0);
    repeat (2) step();

    // Overrun: A, B, C all during A's preamble; C is dropped
    a = rand_pkt();
    b = rand_pkt();
    c = rand_pkt();
    add_expected(a);
    add_expected(b);
    send_pkt(a);
    step();
    send_pkt(b);
    check1("ovr_before_c", overrun, 1'b0);
    send_pkt(c);
    check1("ovr_after_c", overrun, 1'b1);
    wait_done("ovr_a", 500);
    wait_done("ovr_b", 500);
    compare_stream("ovr");
    repeat (5) step();
    check1("ovr_c_not_sent", bit_valid, 1'b0);
    check1("ovr_sticky", overrun, 1'b1);

    // Reset mid-payload: outputs clear asynchronously, nothing resumes
    p = rand_pkt();
    send_pkt(p);
    wait_bits("rst_mid", 40, 500);
    #2 reset = 1'b0;
    #1;
    check1("rst_async_valid", bit_valid, 1'b0);
    check1("rst_async_busy", busy, 1'b0);
    check1("rst_async_overrun", overrun, 1'b0);
    got.delete();
    exp_q.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    idle_valid = 0;
    repeat (20) begin
      step();
      if (bit_valid !== 1'b0) idle_valid++;
    end
    checkn("rst_no_resume_valid", idle_valid, 0);
    checkn("rst_no_resume_bits", got.size(), 0);
    p = rand_pkt();
    add_expected(p);
    send_pkt(p);
    wait_done("rst_next", 500);
    compare_stream("rst_next");

`ifdef PKT_TX_CRC8_EN
    // CRC check value for "123456789"
    for (int i = 0; i < PW; i++) p[i] = 8'h31 + 8'(i);
    add_expected(p);
    send_pkt(p);
    wait_done("crc", 500);
    checkn("crc_bit_count", got.size(), 104);
    crc_seen = 8'h00;
    if (got.size() >= 8)
      for (int i = 0; i < 8; i++) crc_seen[7 - i] = got[got.size() - 8 + i];
    checkn("crc_byte", int'(crc_seen), 32'hF4);
    compare_stream("crc");
`else
    crc_seen = 8'h00;
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
